sega_joy_scanner: RTL

//  Parametrised multi-port Sega DB9 joystick scanner: drives the shared select

---
 rtl/sega_joy_pkg.sv | 57 +++++
 rtl/sega_joy_port_decode.sv | 110 +++++++++++
 rtl/sega_joy_scanner.sv | 116 +++++++++++
 3 files changed

// File: rtl/sega_joy_pkg.sv
// Shared types and constants for the Sega DB9 joystick scanner.
//   phase_t     : scan phase (IDLE, S0..S7)
//   pad_type_t  : detected pad type code reported on type_o
//   BIT_*       : bit positions inside the 12-bit MXYZ SACB RLDU word
//   PIN_*       : pin positions inside one port's 6-bit joy_i field
package sega_joy_pkg;

    localparam int unsigned PIN_W  = 6;
    localparam int unsigned WORD_W = 12;
    localparam int unsigned TYPE_W = 2;

    typedef enum logic [3:0] {
        PH_IDLE = 4'd0,
        PH_S0   = 4'd1,
        PH_S1   = 4'd2,
        PH_S2   = 4'd3,
        PH_S3   = 4'd4,
        PH_S4   = 4'd5,
        PH_S5   = 4'd6,
        PH_S6   = 4'd7,
        PH_S7   = 4'd8
    } phase_t;

    typedef enum logic [1:0] {
        PAD_SMS = 2'b00,
        PAD_MD3 = 2'b01,
        PAD_MD6 = 2'b10
    } pad_type_t;

    // Output word bit positions
    localparam int unsigned BIT_UP    = 0;
    localparam int unsigned BIT_DOWN  = 1;
    localparam int unsigned BIT_LEFT  = 2;
    localparam int unsigned BIT_RIGHT = 3;
    localparam int unsigned BIT_B     = 4;
    localparam int unsigned BIT_C     = 5;
    localparam int unsigned BIT_A     = 6;
    localparam int unsigned BIT_S     = 7;
    localparam int unsigned BIT_Z     = 8;
    localparam int unsigned BIT_Y     = 9;
    localparam int unsigned BIT_X     = 10;
    localparam int unsigned BIT_M     = 11;

    // Raw pin positions within one port's joy_i field
    localparam int unsigned PIN_UP    = 0;
    localparam int unsigned PIN_DOWN  = 1;
    localparam int unsigned PIN_LEFT  = 2;
    localparam int unsigned PIN_RIGHT = 3;
    localparam int unsigned PIN_P6    = 4;
    localparam int unsigned PIN_P9    = 5;

    // Select level driven while in a given phase: low on the odd scan phases
    function automatic logic sel_for_phase(input phase_t ph);
        return !(ph inside {PH_S1, PH_S3, PH_S5, PH_S7});
    endfunction

endpackage

// File: rtl/sega_joy_port_decode.sv
// Per-port decoder: synchronises one DB9 port's pins, builds the shadow
// MXYZ SACB RLDU word across the scan phases, detects pad type, and
// publishes word + type on commit.
//   clk_i, res_n_i : clock, async active-low reset
//   pins_i         : raw pins {p9,p6,right,left,down,up}, active-low
//   phase_i        : current scan phase (phase_t encoding)
//   sample_i       : 1-cycle strobe, sample pins for phase_i
//   commit_i       : 1-cycle strobe, publish shadow word and type
//   joy_o          : published word, active-low
//   type_o         : published pad type
module sega_joy_port_decode
    import sega_joy_pkg::*;
#(
    parameter bit SIX_BTN_EN = 1'b1
) (
    input  logic                clk_i,
    input  logic                res_n_i,
    input  logic [PIN_W-1:0]    pins_i,
    input  logic [3:0]          phase_i,
    input  logic                sample_i,
    input  logic                commit_i,
    output logic [WORD_W-1:0]   joy_o,
    output logic [TYPE_W-1:0]   type_o
);

    phase_t              phase_c;
    logic [PIN_W-1:0]    meta_q;
    logic [PIN_W-1:0]    sync_q;
    logic [WORD_W-1:0]   shadow_q, shadow_d;
    logic [WORD_W-1:0]   joy_q, joy_d;
    logic [TYPE_W-1:0]   type_q, type_d;
    logic                md_q, md_d;
    logic                six_q, six_d;

    assign phase_c = phase_t'(phase_i);

    // Capture and type-decode next-state
    always_comb begin
        shadow_d = shadow_q;
        md_d     = md_q;
        six_d    = six_q;
        joy_d    = joy_q;
        type_d   = type_q;

        if (sample_i) begin
            case (phase_c)
                PH_S0: begin
                    shadow_d[BIT_RIGHT:BIT_UP] = sync_q[PIN_RIGHT:PIN_UP];
                    shadow_d[BIT_B]            = sync_q[PIN_P6];
                    shadow_d[BIT_C]            = sync_q[PIN_P9];
                end
                PH_S1: begin
                    // MD pads pull right and left low while select is low
                    md_d            = ~sync_q[PIN_RIGHT] & ~sync_q[PIN_LEFT];
                    shadow_d[BIT_A] = md_d ? sync_q[PIN_P6] : 1'b1;
                    shadow_d[BIT_S] = md_d ? sync_q[PIN_P9] : 1'b1;
                end
                PH_S4: begin
                    six_d = 1'b0;
                end
                PH_S5: begin
                    // 6-button pads report all four directions low on the third low phase
                    if (SIX_BTN_EN && (sync_q[PIN_RIGHT:PIN_UP] == 4'b0000)) begin
                        six_d = 1'b1;
                    end
                end
                PH_S6: begin
                    shadow_d[BIT_M:BIT_Z] = six_q ? sync_q[PIN_RIGHT:PIN_UP] : 4'hF;
                end
                default: ;
            endcase
        end

        if (commit_i) begin
            joy_d = shadow_q;
            if (SIX_BTN_EN && six_q) begin
                type_d = PAD_MD6;
            end else if (md_q) begin
                type_d = PAD_MD3;
            end else begin
                type_d = PAD_SMS;
            end
        end
    end

    // Synchroniser, shadow and published registers
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            meta_q   <= '1;
            sync_q   <= '1;
            shadow_q <= '1;
            md_q     <= 1'b0;
            six_q    <= 1'b0;
            joy_q    <= '1;
            type_q   <= PAD_SMS;
        end else begin
            meta_q   <= pins_i;
            sync_q   <= meta_q;
            shadow_q <= shadow_d;
            md_q     <= md_d;
            six_q    <= six_d;
            joy_q    <= joy_d;
            type_q   <= type_d;
        end
    end

    assign joy_o  = joy_q;
    assign type_o = type_q;

endmodule

// File: rtl/sega_joy_scanner.sv
// Multi-port Sega DB9 joystick scanner. Steps a phase FSM on tick_i,
// drives the shared select line, and lets per-port decoders build
// MXYZ SACB RLDU words that are published atomically once per scan.
//   clk_i   : system clock
//   res_n_i : async active-low reset
//   tick_i  : 1-cycle phase-step enable
//   joy_i   : per port p [6p+5:6p] = {p9,p6,right,left,down,up}, active-low
//   sel_o   : select (pin 7) drive shared by all ports
//   joy_o   : per port p [12p+11:12p] = MXYZ SACB RLDU, active-low
//   type_o  : per port 00 SMS, 01 MD 3-button, 10 MD 6-button
//   valid_o : 1-cycle pulse when joy_o/type_o update
module sega_joy_scanner
    import sega_joy_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter bit          SIX_BTN_EN = 1'b1,
    parameter int unsigned IDLE_TICKS = 32
) (
    input  logic                          clk_i,
    input  logic                          res_n_i,
    input  logic                          tick_i,
    input  logic [PIN_W*NUM_PORTS-1:0]    joy_i,
    output logic                          sel_o,
    output logic [WORD_W*NUM_PORTS-1:0]   joy_o,
    output logic [TYPE_W*NUM_PORTS-1:0]   type_o,
    output logic                          valid_o
);

    localparam int unsigned CNT_W = $clog2(IDLE_TICKS + 1);

    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_q, sel_d;
    logic               valid_q, valid_d;
    logic               armed_q;
    logic               tick_ok_c;
    logic               sample_c;
    logic               commit_c;

    // Ignores a tick coinciding with the first edge after reset release
    assign tick_ok_c = tick_i & armed_q;

    // Phase sequencing, idle countdown and select drive
    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        sample_c = 1'b0;
        commit_c = 1'b0;

        if (tick_ok_c) begin
            sample_c = (phase_q != PH_IDLE);
            case (phase_q)
                PH_IDLE: begin
                    if (cnt_q == '0) begin
                        phase_d = PH_S0;
                        cnt_d   = CNT_W'(IDLE_TICKS);
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                PH_S0: phase_d = PH_S1;
                PH_S1: phase_d = SIX_BTN_EN ? PH_S2 : PH_S7;
                PH_S2: phase_d = PH_S3;
                PH_S3: phase_d = PH_S4;
                PH_S4: phase_d = PH_S5;
                PH_S5: phase_d = PH_S6;
                PH_S6: phase_d = PH_S7;
                PH_S7: begin
                    phase_d  = PH_IDLE;
                    valid_d  = 1'b1;
                    commit_c = 1'b1;
                end
                default: phase_d = PH_IDLE;
            endcase
        end

        sel_d = sel_for_phase(phase_d);
    end

    // FSM state and registered outputs
    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            phase_q <= PH_IDLE;
            cnt_q   <= CNT_W'(IDLE_TICKS);
            sel_q   <= 1'b1;
            valid_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            armed_q <= 1'b1;
        end
    end

    assign sel_o   = sel_q;
    assign valid_o = valid_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        sega_joy_port_decode #(
            .SIX_BTN_EN (SIX_BTN_EN)
        ) u_dec (
            .clk_i    (clk_i),
            .res_n_i  (res_n_i),
            .pins_i   (joy_i[PIN_W*p +: PIN_W]),
            .phase_i  (phase_q),
            .sample_i (sample_c),
            .commit_i (commit_c),
            .joy_o    (joy_o[WORD_W*p +: WORD_W]),
            .type_o   (type_o[TYPE_W*p +: TYPE_W])
        );
    end

endmodule
